// File: rtl/rs_issue_sched_pkg.sv
// Shared types and per-station defaults for the reservation-station issue scheduler.
// No logic: types, sizing constants and a saturating-increment helper.
// Imported by rs_age_matrix and rs_issue_sched.
package rs_issue_sched_pkg;

    typedef enum logic {
        SCHED_SELECT = 1'b0,
        SCHED_HOLD   = 1'b1
    } rs_sched_state_t;

    localparam int RS_DEPTH_INT  = 8;
    localparam int RS_DEPTH_INTM = 4;
    localparam int RS_DEPTH_BR   = 4;
    localparam int RS_DEPTH_MEM  = 8;

    localparam int PERF_CNT_W = 32;

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + PERF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for one RS: older[i][j]=1 means entry j is older than entry i.
// Latency: oldest is combinational from req; matrix updates on the clock edge.
// Backpressure: none; alloc/free are applied every edge, flush clears everything.
module rs_age_matrix
    import rs_issue_sched_pkg::*;
#(
    parameter int RS_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [RS_DEPTH-1:0] alloc_en,
    input  logic [RS_DEPTH-1:0] entry_valid,
    input  logic [RS_DEPTH-1:0] freed,
    input  logic [RS_DEPTH-1:0] req,
    output logic [RS_DEPTH-1:0] oldest
);

    logic [RS_DEPTH-1:0] older   [RS_DEPTH];
    logic [RS_DEPTH-1:0] row_new [RS_DEPTH];

    // A new entry is younger than every surviving entry and than lower-index co-allocations.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            row_new[i] = ((entry_valid & ~freed & ~alloc_en)
                          | (alloc_en & ((RS_DEPTH'(1) << i) - RS_DEPTH'(1))))
                         & ~(RS_DEPTH'(1) << i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (alloc_en[i]) begin
                    older[i] <= row_new[i];
                end else begin
                    older[i] <= older[i] & ~alloc_en;
                end
            end
        end
    end

    always_comb begin
        oldest = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            oldest[i] = req[i] && !(|(older[i] & req));
        end
    end

    a_oldest_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(oldest));

endmodule

// File: rtl/rs_issue_sched.sv
// Oldest-ready issue scheduler for one RS; optional perf counters under RS_ISSUE_PERF_EN.
// Latency: entry_ready -> issue_valid combinational in SELECT; issue_fire is combinational.
// Backpressure: fu_ready low holds the offered index stable (HOLD) until accepted.
module rs_issue_sched
    import rs_issue_sched_pkg::*;
#(
    parameter  int RS_DEPTH = 8,
    localparam int IDX_W    = $clog2(RS_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [RS_DEPTH-1:0] alloc_en,
    input  logic [RS_DEPTH-1:0] entry_valid,
    input  logic [RS_DEPTH-1:0] entry_ready,
    output logic                issue_valid,
    output logic [IDX_W-1:0]    issue_idx,
    input  logic                fu_ready,
    output logic                issue_fire
);

    rs_sched_state_t     state;
    logic [IDX_W-1:0]    lock_idx;
    logic [RS_DEPTH-1:0] cand;
    logic [RS_DEPTH-1:0] oldest;
    logic [RS_DEPTH-1:0] freed;
    logic [RS_DEPTH-1:0] alloc_eff;
    logic [IDX_W-1:0]    sel_idx;

    assign cand      = entry_valid & entry_ready;
    assign freed     = issue_fire ? (RS_DEPTH'(1) << issue_idx) : '0;
    assign alloc_eff = flush ? '0 : alloc_en;

    rs_age_matrix #(
        .RS_DEPTH (RS_DEPTH)
    ) u_age (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .alloc_en    (alloc_eff),
        .entry_valid (entry_valid),
        .freed       (freed),
        .req         (cand),
        .oldest      (oldest)
    );

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (oldest[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        if (rst || flush) begin
            issue_valid = 1'b0;
        end else if (state == SCHED_HOLD) begin
            issue_valid = 1'b1;
        end else begin
            issue_valid = |cand;
        end
    end

    assign issue_idx  = (state == SCHED_HOLD) ? lock_idx : sel_idx;
    assign issue_fire = issue_valid && fu_ready;

    // Lock clears on the accepting edge, which is also when the RS frees the entry.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state    <= SCHED_SELECT;
            lock_idx <= '0;
        end else begin
            case (state)
                SCHED_SELECT: begin
                    if (issue_valid && !fu_ready) begin
                        state    <= SCHED_HOLD;
                        lock_idx <= sel_idx;
                    end
                end
                SCHED_HOLD: begin
                    if (fu_ready) begin
                        state    <= SCHED_SELECT;
                        lock_idx <= '0;
                    end
                end
            endcase
        end
    end

`ifdef RS_ISSUE_PERF_EN
    logic [PERF_CNT_W-1:0] perf_issue_cnt;
    logic [PERF_CNT_W-1:0] perf_fu_stall_cnt;
    logic [PERF_CNT_W-1:0] perf_no_ready_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issue_cnt    <= '0;
            perf_fu_stall_cnt <= '0;
            perf_no_ready_cnt <= '0;
        end else begin
            if (issue_fire) begin
                perf_issue_cnt <= sat_inc(perf_issue_cnt);
            end
            if (issue_valid && !fu_ready) begin
                perf_fu_stall_cnt <= sat_inc(perf_fu_stall_cnt);
            end
            if ((|entry_valid) && (cand == '0)) begin
                perf_no_ready_cnt <= sat_inc(perf_no_ready_cnt);
            end
        end
    end
`endif

    a_no_alloc_on_issue: assert property (@(posedge clk) disable iff (rst)
        !(issue_fire && alloc_eff[issue_idx]));

    a_lock_valid: assert property (@(posedge clk) disable iff (rst)
        (state == SCHED_HOLD) |-> entry_valid[lock_idx]);

endmodule

// File: tb/tb_rs_issue_sched.sv
// Bench for rs_issue_sched: the bench plays the RS, a timestamp-age model predicts each cycle.
// Stimulus pushes expectations into a scoreboard queue; a negedge monitor pops and compares.
module tb_rs_issue_sched;
    import rs_issue_sched_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic [N-1:0] alloc_en = '0;
    logic [N-1:0] entry_valid = '0;
    logic [N-1:0] entry_ready = '0;
    logic         fu_ready = 1'b0;
    logic         issue_valid;
    logic [2:0]   issue_idx;
    logic         issue_fire;

    always #5 clk = ~clk;

    rs_issue_sched #(.RS_DEPTH(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .alloc_en    (alloc_en),
        .entry_valid (entry_valid),
        .entry_ready (entry_ready),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .fu_ready    (fu_ready),
        .issue_fire  (issue_fire)
    );

    typedef struct packed {
        logic       v;
        logic [2:0] idx;
        logic       chk_idx;
        logic       f;
        logic [7:0] tag;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: an entry's age is the sequence number it was allocated with.
    bit   m_valid[N];
    int   m_stamp[N];
    int   seq = 0;
    bit   m_hold = 0;
    int   m_lock = 0;

    bit         p_rst = 1, p_flush = 0, p_fire = 0, p_v = 0, p_fr = 0;
    int         p_idx = 0;
    logic [N-1:0] p_alloc = '0;

    task automatic chk(input string name, input int tag, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s test=%0d got=%0d want=%0d at %0t", name, tag, got, want, $time);
        end
    endtask

    function automatic void apply_edge();
        if (p_rst || p_flush) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
            m_hold = 0;
        end else begin
            if (p_fire) begin
                m_valid[p_idx] = 0;
                m_hold = 0;
            end else if (p_v && !p_fr) begin
                m_hold = 1;
                m_lock = p_idx;
            end
            for (int i = 0; i < N; i++) begin
                if (p_alloc[i]) begin
                    m_valid[i] = 1;
                    m_stamp[i] = seq;
                    seq++;
                end
            end
        end
    endfunction

    task automatic step(input bit r, input bit fl, input logic [N-1:0] al,
                        input logic [N-1:0] rdy, input bit fr, input int tag);
        exp_t         e;
        int           best;
        logic [N-1:0] vv;
        @(posedge clk);
        apply_edge();
        #1;
        for (int i = 0; i < N; i++) vv[i] = m_valid[i];
        rst         = r;
        flush       = fl;
        alloc_en    = al & ~vv;
        entry_valid = vv;
        entry_ready = rdy;
        fu_ready    = fr;
        e = '0;
        e.tag = 8'(tag);
        e.chk_idx = 1'b1;
        if (r || fl) begin
            e.chk_idx = 1'b0;
        end else if (m_hold) begin
            e.v   = 1'b1;
            e.idx = 3'(m_lock);
        end else begin
            best = -1;
            for (int i = 0; i < N; i++) begin
                if (m_valid[i] && rdy[i] && (best < 0 || m_stamp[i] < m_stamp[best])) best = i;
            end
            if (best >= 0) begin
                e.v   = 1'b1;
                e.idx = 3'(best);
            end
        end
        e.f = e.v && fr;
        sbq.push_back(e);
        p_rst = r; p_flush = fl; p_alloc = r ? '0 : (al & ~vv);
        p_fire = e.f; p_v = e.v; p_idx = int'(e.idx); p_fr = fr;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("issue_valid", int'(e.tag), int'(issue_valid), int'(e.v));
                chk("issue_fire", int'(e.tag), int'(issue_fire), int'(e.f));
                if (e.chk_idx) chk("issue_idx", int'(e.tag), int'(issue_idx), int'(e.idx));
            end
        end
    end

    initial begin : stim
        int unsigned bound;
        // 1: reset then idle
        step(1, 0, 8'h00, 8'h00, 0, 1);
        step(1, 0, 8'h00, 8'h00, 0, 1);
        for (int k = 0; k < 10; k++) step(0, 0, 8'h00, 8'h00, 1, 1);
        // 2: age order 5, 2, 7
        step(0, 0, 8'h20, 8'hFF, 1, 2);
        step(0, 0, 8'h04, 8'hFF, 1, 2);
        step(0, 0, 8'h80, 8'hFF, 1, 2);
        step(0, 0, 8'h00, 8'hFF, 1, 2);
        step(0, 0, 8'h00, 8'hFF, 1, 2);
        // 3: same-cycle alloc of 1 and 3
        step(0, 0, 8'h0A, 8'hFF, 1, 3);
        step(0, 0, 8'h00, 8'hFF, 1, 3);
        step(0, 0, 8'h00, 8'hFF, 1, 3);
        step(0, 0, 8'h00, 8'hFF, 1, 3);
        // 4: hold stability while older slot 0 becomes ready
        step(0, 0, 8'h01, 8'h00, 1, 4);
        step(0, 0, 8'h10, 8'h00, 1, 4);
        step(0, 0, 8'h00, 8'h10, 0, 4);
        step(0, 0, 8'h00, 8'h11, 0, 4);
        step(0, 0, 8'h00, 8'h11, 0, 4);
        step(0, 0, 8'h00, 8'h11, 1, 4);
        step(0, 0, 8'h00, 8'h11, 1, 4);
        step(0, 0, 8'h00, 8'h11, 1, 4);
        // 5: flush in HOLD, then a fresh slot 6 issues alone
        step(0, 0, 8'h08, 8'h00, 1, 5);
        step(0, 0, 8'h00, 8'h08, 0, 5);
        step(0, 0, 8'h00, 8'h08, 0, 5);
        step(0, 1, 8'h01, 8'h08, 0, 5);
        step(0, 0, 8'h40, 8'hFF, 1, 5);
        step(0, 0, 8'h00, 8'hFF, 1, 5);
        step(0, 0, 8'h00, 8'hFF, 1, 5);
        // 7: randomized traffic
        for (int k = 0; k < 600; k++) begin
            step(0, ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                 8'($urandom), ($urandom_range(0, 3) != 0), 7);
        end
        for (int k = 0; k < 12; k++) step(0, 0, 8'h00, 8'hFF, 1, 7);
`ifdef RS_ISSUE_PERF_EN
        // 6: 4 not-ready cycles, 2 stalls, 3 fires
        step(1, 0, 8'h00, 8'h00, 0, 6);
        step(1, 0, 8'h00, 8'h00, 0, 6);
        step(0, 0, 8'h07, 8'h00, 1, 6);
        for (int k = 0; k < 4; k++) step(0, 0, 8'h00, 8'h00, 1, 6);
        step(0, 0, 8'h00, 8'hFF, 0, 6);
        step(0, 0, 8'h00, 8'hFF, 0, 6);
        for (int k = 0; k < 3; k++) step(0, 0, 8'h00, 8'hFF, 1, 6);
        step(0, 0, 8'h00, 8'h00, 1, 6);
        chk("perf_issue_cnt", 6, int'(dut.perf_issue_cnt), 3);
        chk("perf_fu_stall_cnt", 6, int'(dut.perf_fu_stall_cnt), 2);
        chk("perf_no_ready_cnt", 6, int'(dut.perf_no_ready_cnt), 4);
`endif
        bound = 0;
        while (sbq.size() > 0 && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        chk("scoreboard_drained", 0, sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
